sync_word_scheduler: RTL and testbench

Round-robin scheduler that shares one multi-bit `synchronizer` input bus among `NUM_REQ` requesters in the source clock domain. It accepts one word at a time over a valid/ready handshake and drives it, with a requester tag and a toggle flag, onto the synchronizer input. It then holds that value stable for `HOLD_CYCLES` cycles, so every bit settles through the destination's `NUM_FFS` flop chain before the bus changes. It sits in front of the CDC synchronizer on the SERDES control/status path.

---
 rtl/sync_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/sync_word_scheduler.sv | 107 ++++++++++
 tb/tb_sync_word_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_sched_pkg.sv
// Purpose   : shared types and helpers for the synchronizer word scheduler.
// Latency   : n/a (package only).
// Backpress : n/a (package only).
// Contents  : sched_state_t FSM encoding; tag_w(n) = max(1, $clog2(n)) sizes
//             requester tags, pointers and the hold counter.
package sync_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    // A single-value field still needs one bit, so clamp the width at 1.
    function automatic int tag_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose   : combinational N-way arbiter with a one-hot grant and a grant index.
// Latency   : 0 cycles (pure combinational).
// Backpress : none; a grant is issued only for an asserted request.
// Ports     : req (request vector), ptr (rotation start index),
//             gnt (one-hot grant), gnt_idx (index of the granted request).
// Config    : SYNC_SCHED_FIXED_PRIO_EN selects fixed priority (lowest index
//             wins, ptr ignored); otherwise the search starts at ptr and wraps.
module rr_arbiter
    import sync_sched_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = tag_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

`ifdef SYNC_SCHED_FIXED_PRIO_EN

    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = W'(i);
            end
        end
    end

`else

    // Walk the requests starting at ptr; the modulo wraps past N-1 back to 0.
    always_comb begin
        logic found;
        int   idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = W'(idx);
            end
        end
    end

`endif

endmodule

// File: rtl/sync_word_scheduler.sv
// Purpose   : shares one multi-bit CDC synchronizer input among NUM_REQ requesters.
// Latency   : accept-to-bus 1 cycle; bus then held HOLD_CYCLES cycles (busy).
// Backpress : o_ready is zero while busy or in reset; one grant per HOLD_CYCLES+1.
// Ports     : i_valid/i_data/o_ready per-requester handshake (requester k owns
//             i_data[k*DATA_WIDTH +: DATA_WIDTH]); o_sync_data/o_sync_tag/
//             o_sync_toggle feed the synchronizer; o_busy marks the hold window.
// Config    : SYNC_SCHED_FIXED_PRIO_EN -> fixed priority, no rotation pointer.
module sync_word_scheduler
    import sync_sched_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_WIDTH  = 9,
    parameter  int NUM_FFS     = 4,
    parameter  int HOLD_CYCLES = NUM_FFS + 2,
    localparam int TAG_W       = tag_w(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    output logic [NUM_REQ-1:0]            o_ready,
    output logic [DATA_WIDTH-1:0]         o_sync_data,
    output logic [TAG_W-1:0]              o_sync_tag,
    output logic                          o_sync_toggle,
    output logic                          o_busy
);

    localparam int CNT_W = tag_w(HOLD_CYCLES);

    // Every bit must have passed the destination flop chain before the bus moves.
    if (HOLD_CYCLES < NUM_FFS + 1) begin : g_bad_hold
        $error("sync_word_scheduler: HOLD_CYCLES must be >= NUM_FFS+1");
    end
    if (NUM_REQ < 2) begin : g_bad_req
        $error("sync_word_scheduler: NUM_REQ must be >= 2");
    end

    sched_state_t            state;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_REQ-1:0]      arb_req;
    logic [NUM_REQ-1:0]      gnt;
    logic [TAG_W-1:0]        gnt_idx;
    logic [TAG_W-1:0]        arb_ptr;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   sel_word;

    // Requests are only visible to the arbiter while IDLE and out of reset,
    // so o_ready is naturally all-zero in HOLD and while reset is asserted.
    assign arb_req  = (state == IDLE && !i_reset) ? i_valid : '0;
    assign o_ready  = gnt;
    assign xfer     = |gnt;
    assign sel_word = i_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign o_busy   = (state == HOLD);

    rr_arbiter #(
        .N       (NUM_REQ)
    ) u_arb (
        .req     (arb_req),
        .ptr     (arb_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

`ifdef SYNC_SCHED_FIXED_PRIO_EN
    assign arb_ptr = '0;
`else
    logic [TAG_W-1:0] rr_ptr;

    // The winner's successor gets first look next time; moves only on a transfer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign arb_ptr = rr_ptr;
`endif

    // Data, tag and toggle all load on the same edge so the destination sees a
    // consistent word whenever it observes the toggle flip.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            cnt           <= '0;
            o_sync_data   <= '0;
            o_sync_tag    <= '0;
            o_sync_toggle <= 1'b0;
        end else if (state == IDLE) begin
            if (xfer) begin
                state         <= HOLD;
                cnt           <= CNT_W'(HOLD_CYCLES - 1);
                o_sync_data   <= sel_word;
                o_sync_tag    <= gnt_idx;
                o_sync_toggle <= ~o_sync_toggle;
            end
        end else begin
            if (cnt == '0) begin
                state <= IDLE;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_word_scheduler.sv
// Purpose   : self-checking bench for sync_word_scheduler (4 requesters, 9-bit, hold 6).
// Latency   : checks 1-cycle load latency and the 7-cycle grant spacing.
// Backpress : checks o_ready is zero in reset and throughout the hold window.
module tb_sync_word_scheduler;

    localparam int NR = 4;
    localparam int DW = 9;
    localparam int HC = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NR-1:0]  valid = '0;
    logic [NR-1:0][DW-1:0] data = '0;
    logic [NR-1:0]  ready;
    logic [DW-1:0]  sdata;
    logic [1:0]     stag;
    logic           stog;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sync_word_scheduler #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .NUM_FFS     (4),
        .HOLD_CYCLES (HC)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_valid       (valid),
        .i_data        (data),
        .o_ready       (ready),
        .o_sync_data   (sdata),
        .o_sync_tag    (stag),
        .o_sync_toggle (stog),
        .o_busy        (busy)
    );

    typedef struct {
        logic [3:0]          valid;
        logic [3:0][DW-1:0]  d;
        logic [3:0]          rdy;
        logic [DW-1:0]       odat;
        logic [1:0]          otag;
        logic                otog;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        valid = '0;
        data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference arbitration: first asserted requester at or after the pointer.
    function automatic int pick(input logic [3:0] v, input int ptr);
        int start;
`ifdef SYNC_SCHED_FIXED_PRIO_EN
        start = 0;
`else
        start = ptr;
`endif
        for (int i = 0; i < NR; i++) if (v[(start + i) % NR]) return (start + i) % NR;
        return -1;
    endfunction

    task automatic wait_grant(output int idx, output int at);
        idx = -1;
        at  = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ready != '0) begin
                idx = oh_idx(ready);
                at  = cyc;
                break;
            end
        end
        if (idx < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout: got no grant within 20 cycles, required one");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, at, prev, n;
        int m_free, m_ptr, m_tag, m_tog, e_idx;
        logic [DW-1:0] m_data;
        logic [3:0]    e_rdy;

        // ---------------- table-driven single-grant vectors (pointer at 0) ----
        tbl[0] = '{4'b0000, {9'h000, 9'h000, 9'h000, 9'h000}, 4'b0000, 9'h000, 2'd0, 1'b0};
        tbl[1] = '{4'b1000, {9'h1F0, 9'h000, 9'h000, 9'h000}, 4'b1000, 9'h1F0, 2'd3, 1'b1};
        tbl[2] = '{4'b0110, {9'h000, 9'h155, 9'h0AA, 9'h000}, 4'b0010, 9'h0AA, 2'd1, 1'b1};
        tbl[3] = '{4'b1111, {9'h004, 9'h003, 9'h002, 9'h1FF}, 4'b0001, 9'h1FF, 2'd0, 1'b1};
        tbl[4] = '{4'b0100, {9'h000, 9'h0C3, 9'h000, 9'h000}, 4'b0100, 9'h0C3, 2'd2, 1'b1};
        tbl[5] = '{4'b1100, {9'h111, 9'h122, 9'h000, 9'h000}, 4'b0100, 9'h122, 2'd2, 1'b1};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            valid = tbl[i].valid;
            data  = tbl[i].d;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1 valid = '0;
            @(negedge clk);
            chk($sformatf("tbl%0d_data", i), 32'(sdata), 32'(tbl[i].odat));
            chk($sformatf("tbl%0d_tag", i),  32'(stag),  32'(tbl[i].otag));
            chk($sformatf("tbl%0d_tog", i),  32'(stog),  32'(tbl[i].otog));
            chk($sformatf("tbl%0d_busy", i), 32'(busy),  32'(tbl[i].rdy != 0));
        end

        // ---------------- single requester 2, data 0x1A5 ----------------------
        do_reset();
        valid   = 4'b0100;
        data[2] = 9'h1A5;
        @(negedge clk);
        chk("solo_ready_N", 32'(ready), 32'h4);
        for (int k = 1; k <= HC; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("solo_data", 32'(sdata), 32'h1A5);
                chk("solo_tag",  32'(stag),  32'd2);
                chk("solo_tog",  32'(stog),  32'd1);
            end
            chk($sformatf("solo_busy_N%0d", k),  32'(busy),  32'd1);
            chk($sformatf("solo_ready_N%0d", k), 32'(ready), 32'd0);
        end
        @(negedge clk);
        chk("solo_busy_N7",  32'(busy),  32'd0);
        chk("solo_ready_N7", 32'(ready), 32'h4);

        // ---------------- reset with all valid, then fair rotation ------------
        @(posedge clk);
        #1 valid = 4'hF;
        data = {9'h103, 9'h102, 9'h101, 9'h100};
        rst  = 1'b1;
        #1;
        chk("rst_async_data",  32'(sdata), 32'd0);
        chk("rst_async_tag",   32'(stag),  32'd0);
        chk("rst_async_tog",   32'(stog),  32'd0);
        chk("rst_async_busy",  32'(busy),  32'd0);
        chk("rst_async_ready", 32'(ready), 32'd0);
        @(negedge clk);
        chk("rst_hold_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rot_first_ready", 32'(ready), 32'h1);
        prev = cyc;
        @(negedge clk);
        chk("rot0_data", 32'(sdata), 32'h100);
        chk("rot0_tog",  32'(stog),  32'd1);
        for (int g = 1; g <= 4; g++) begin
`ifdef SYNC_SCHED_FIXED_PRIO_EN
            n = 0;
`else
            n = g % NR;
`endif
            wait_grant(idx, at);
            chk($sformatf("rot%0d_idx", g),     32'(idx),       32'(n));
            chk($sformatf("rot%0d_spacing", g), 32'(at - prev), 32'(HC + 1));
            prev = at;
            @(negedge clk);
            chk($sformatf("rot%0d_data", g), 32'(sdata), 32'(9'h100 + n));
            chk($sformatf("rot%0d_tag", g),  32'(stag),  32'(n));
            chk($sformatf("rot%0d_tog", g),  32'(stog),  32'((g % 2) == 0));
        end

        // ---------------- back-to-back words from requester 1 -----------------
        do_reset();
        valid   = 4'b0010;
        data[1] = 9'h0FF;
        @(negedge clk);
        chk("b2b_first_ready", 32'(ready), 32'h2);
        n = cyc;
        @(posedge clk);
        #1 data[1] = 9'h001;
        for (int k = 1; k <= HC + 1; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_hold_data_%0d", k), 32'(sdata), 32'h0FF);
        end
        chk("b2b_second_ready", 32'(ready),   32'h2);
        chk("b2b_spacing",      32'(cyc - n), 32'(HC + 1));
        @(negedge clk);
        chk("b2b_second_data", 32'(sdata), 32'h001);
        chk("b2b_second_tog",  32'(stog),  32'd0);

        // ---------------- reset pulsed mid-hold (cnt == 3) --------------------
        do_reset();
        valid   = 4'b0001;
        data[0] = 9'h055;
        @(negedge clk);
        chk("midrst_ready", 32'(ready), 32'h1);
        @(posedge clk);
        #1 valid = '0;
        repeat (3) @(negedge clk);
        chk("midrst_busy_before", 32'(busy),  32'd1);
        chk("midrst_data_before", 32'(sdata), 32'h055);
        rst = 1'b1;
        #1;
        chk("midrst_data", 32'(sdata), 32'd0);
        chk("midrst_tag",  32'(stag),  32'd0);
        chk("midrst_tog",  32'(stog),  32'd0);
        chk("midrst_busy", 32'(busy),  32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        valid = 4'b1010;
        @(negedge clk);
        chk("midrst_next_ready", 32'(ready), 32'h2);

        // ---------------- requesters 1 and 3 held -----------------------------
        do_reset();
        valid = 4'b1010;
        data  = {9'h033, 9'h000, 9'h011, 9'h000};
        for (int g = 0; g < 4; g++) begin
`ifdef SYNC_SCHED_FIXED_PRIO_EN
            n = 1;
`else
            n = (g % 2 == 0) ? 1 : 3;
`endif
            wait_grant(idx, at);
            chk($sformatf("pair%0d_idx", g), 32'(idx), 32'(n));
            @(negedge clk);
        end

        // ---------------- randomized run against the reference model ----------
        do_reset();
        m_free = 0; m_ptr = 0; m_tag = 0; m_tog = 0; m_data = '0;
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 3) == 0) valid = 4'(1 << $urandom_range(0, 3));
            else                           valid = 4'($urandom_range(0, 15));
            for (int k = 0; k < NR; k++) data[k] = DW'($urandom);
            @(negedge clk);
            e_idx = (t >= m_free) ? pick(valid, m_ptr) : -1;
            e_rdy = (e_idx >= 0) ? 4'(1 << e_idx) : 4'b0000;
            chk($sformatf("rnd%0d_ready", t), 32'(ready), 32'(e_rdy));
            chk($sformatf("rnd%0d_busy", t),  32'(busy),  32'(t < m_free));
            chk($sformatf("rnd%0d_data", t),  32'(sdata), 32'(m_data));
            chk($sformatf("rnd%0d_tag", t),   32'(stag),  32'(m_tag));
            chk($sformatf("rnd%0d_tog", t),   32'(stog),  32'(m_tog));
            if (e_idx >= 0) begin
                m_data = data[e_idx];
                m_tag  = e_idx;
                m_tog  = m_tog ^ 1;
                m_free = t + HC + 1;
                m_ptr  = (e_idx + 1) % NR;
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
